// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions for the key-schedule blocks.
//   - NK / NR         : AES-128 key length in words and number of rounds
//   - state_t         : key-schedule FSM states (IDLE / FWD / EMIT)
//   - gf_mul          : GF(2^8) multiply, polynomial x^8+x^4+x^3+x+1
//   - sbox            : AES S-box byte (multiplicative inverse + affine map)
//   - rcon            : round constant top byte for rounds 1..10
//   - rot_word        : cyclic left rotation of a word by one byte
package aes_pkg;

  localparam int NK = 4;
  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      else      p = p;
      if (x[7]) x = {x[6:0], 1'b0} ^ 8'h1b;
      else      x = {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Inverse computed as a^254 (square-and-multiply); 0 maps to 0 naturally.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational SubWord, four parallel S-box bytes.
//   din  [31:0] : input word
//   dout [31:0] : S-box applied to each byte of din
module aes_sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  import aes_pkg::*;

  assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: AES-128 round-key generator for decryption.
// Accepts a cipher key, runs the forward schedule for 10 cycles to reach
// round key 10, then streams round keys 10..0 using the inverse recurrence.
// Optional build macro KEYSCHED_CACHE_EN keeps the last final round key so the
// same key set can be replayed without the forward pass.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   key_valid/key_ready     : cipher key handshake (key_ready high only in IDLE)
//   key_in [127:0]          : cipher key, [127:96] = w0
//   replay_valid            : re-stream cached key set (cache build only)
//   cache_hit               : a cached final round key is held
//   rk_valid/rk_ready       : round key handshake
//   rk_data [127:0]         : round key, [127:96] = word 0 of the round
//   rk_round [3:0]          : round index of rk_data (10..0)
//   rk_last                 : rk_round == 0
module aes_inv_key_sched #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         replay_valid,
  output logic         cache_hit,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last
);
  import aes_pkg::*;

  if (NR != aes_pkg::NR) begin : g_nr_check
    $error("aes_inv_key_sched supports only NR=10");
  end

  localparam logic [3:0] LAST_ROUND = 4'd10;

  state_t       state_r;
  logic [127:0] work_r;
  logic [3:0]   round_r;
  logic         rk_valid_r;
  logic         rk_last_r;
  logic         key_ready_r;

  logic [31:0]  a0_s, a1_s, a2_s, a3_s;
  logic [31:0]  b1_s, b2_s, b3_s;
  logic [31:0]  f0_s, f1_s, f2_s, f3_s;
  logic [31:0]  sw_in_s;
  logic [31:0]  sw_out_s;
  logic [31:0]  rc_word_s;
  logic [127:0] fwd_next_s;
  logic [127:0] bwd_next_s;
  logic [127:0] cache_word_s;
  logic         replay_go_s;

  assign a0_s = work_r[127:96];
  assign a1_s = work_r[95:64];
  assign a2_s = work_r[63:32];
  assign a3_s = work_r[31:0];

  // In EMIT the S-box works on the previous round's w3, which is a3^a2.
  assign b3_s = a3_s ^ a2_s;
  assign b2_s = a2_s ^ a1_s;
  assign b1_s = a1_s ^ a0_s;

  assign sw_in_s   = (state_r == EMIT) ? rot_word(b3_s) : rot_word(a3_s);
  assign rc_word_s = {rcon(round_r), 24'h000000};

  aes_sub_word u_sub_word (
    .din  (sw_in_s),
    .dout (sw_out_s)
  );

  assign f0_s       = a0_s ^ sw_out_s ^ rc_word_s;
  assign f1_s       = a1_s ^ f0_s;
  assign f2_s       = a2_s ^ f1_s;
  assign f3_s       = a3_s ^ f2_s;
  assign fwd_next_s = {f0_s, f1_s, f2_s, f3_s};
  assign bwd_next_s = {a0_s ^ sw_out_s ^ rc_word_s, b1_s, b2_s, b3_s};

`ifdef KEYSCHED_CACHE_EN
  logic [127:0] cache_r;
  logic         cache_hit_r;

  // Capture the final round key as FWD hands over to EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_r     <= 128'h0;
      cache_hit_r <= 1'b0;
    end else if (state_r == FWD && round_r == LAST_ROUND) begin
      cache_r     <= fwd_next_s;
      cache_hit_r <= 1'b1;
    end
  end

  assign cache_word_s = cache_r;
  assign replay_go_s  = replay_valid & cache_hit_r;
  assign cache_hit    = cache_hit_r;
`else
  logic unused_replay_s;

  assign unused_replay_s = replay_valid;
  assign cache_word_s    = 128'h0;
  assign replay_go_s     = 1'b0;
  assign cache_hit       = 1'b0;
`endif

  // FSM, round counter, working register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      work_r      <= 128'h0;
      round_r     <= 4'd0;
      rk_valid_r  <= 1'b0;
      rk_last_r   <= 1'b0;
      key_ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          // A new key takes priority over a replay request.
          if (key_valid) begin
            work_r      <= key_in;
            round_r     <= 4'd1;
            rk_last_r   <= 1'b0;
            key_ready_r <= 1'b0;
            state_r     <= FWD;
          end else if (replay_go_s) begin
            work_r      <= cache_word_s;
            round_r     <= LAST_ROUND;
            rk_last_r   <= 1'b0;
            rk_valid_r  <= 1'b1;
            key_ready_r <= 1'b0;
            state_r     <= EMIT;
          end
        end
        FWD: begin
          work_r <= fwd_next_s;
          if (round_r == LAST_ROUND) begin
            rk_valid_r <= 1'b1;
            state_r    <= EMIT;
          end else begin
            round_r <= round_r + 4'd1;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (rk_last_r) begin
              rk_valid_r  <= 1'b0;
              key_ready_r <= 1'b1;
              state_r     <= IDLE;
            end else begin
              work_r    <= bwd_next_s;
              round_r   <= round_r - 4'd1;
              rk_last_r <= (round_r == 4'd1);
            end
          end
        end
        default: begin
          rk_valid_r  <= 1'b0;
          key_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign key_ready = key_ready_r;
  assign rk_valid  = rk_valid_r;
  assign rk_data   = work_r;
  assign rk_round  = round_r;
  assign rk_last   = rk_last_r;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: scoreboard bench for aes_inv_key_sched.
// Expected round keys come from an independent forward key expansion
// (S-box built by brute-force inverse search) plus FIPS-197 spot values.
// Compile with +define+KEYSCHED_CACHE_EN to exercise the replay cache.
module tb_aes_inv_key_sched;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] data;
  } sb_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         replay_valid;
  logic         cache_hit;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] model_rk [0:10];
  logic [127:0] spot [0:10];
  bit           spot_en [0:10];
  sb_t          sb_q [$];

  aes_inv_key_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_in       (key_in),
    .replay_valid (replay_valid),
    .cache_hit    (cache_hit),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .rk_data      (rk_data),
    .rk_round     (rk_round),
    .rk_last      (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xtime(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) begin
        s = s ^ inv;
        inv = {inv[6:0], inv[7]};
      end
      sb[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
        rc = tb_xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_expected(input logic [127:0] k);
    sb_t e;
    model_expand(k);
    for (int r = 10; r >= 0; r--) begin
      e.round = 4'(r);
      e.data  = model_rk[r];
      sb_q.push_back(e);
    end
  endtask

  task automatic set_spots(input bit fips);
    for (int r = 0; r < 11; r++) begin
      spot_en[r] = 1'b0;
      spot[r]    = 128'h0;
    end
    spot_en[10] = 1'b1;
    spot_en[0]  = 1'b1;
    if (fips) begin
      spot_en[9] = 1'b1;
      spot_en[1] = 1'b1;
      spot[10]   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      spot[9]    = 128'hac7766f319fadc2128d12941575c006e;
      spot[1]    = 128'ha0fafe1788542cb123a339392a6c7605;
      spot[0]    = FIPS_KEY;
    end else begin
      spot[10]   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
      spot[0]    = ZERO_KEY;
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_key_ready"}, 128'(key_ready), 128'd1);
    check_val({tag, "_rk_valid"},  128'(rk_valid),  128'd0);
    check_val({tag, "_rk_data"},   rk_data,         128'd0);
    check_val({tag, "_rk_round"},  128'(rk_round),  128'd0);
    check_val({tag, "_rk_last"},   128'(rk_last),   128'd0);
    check_val({tag, "_cache_hit"}, 128'(cache_hit), 128'd0);
  endtask

  // Waits for key_ready (bounded) and performs one key handshake.
  task automatic send_key(input logic [127:0] k);
    int c;
    c = 0;
    while (!key_ready && c < 50) begin
      @(posedge clk); #1; c++;
    end
    check_val("key_ready_wait", 128'(key_ready), 128'd1);
    key_valid = 1'b1;
    key_in    = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  // Starts right after the accepting edge; checks latency, then drains 11 keys.
  task automatic consume(input int stall_pct, input bit poke, input int lat);
    int           c;
    bit           done;
    bit           stalled;
    logic [127:0] held;
    sb_t          e;
    c = 1;
    rk_ready = 1'b1;
    while (!rk_valid && c < 40) begin
      key_valid = (poke && c == 3);
      key_in    = 128'hdeadbeef_00112233_44556677_8899aabb;
      if (poke && c == 3) check_val("key_ready_fwd", 128'(key_ready), 128'd0);
      @(posedge clk); #1; c++;
    end
    key_valid = 1'b0;
    check_val("first_latency", 128'(c), 128'(lat));
    done    = 1'b0;
    stalled = 1'b0;
    held    = 128'h0;
    c       = 0;
    while (!done && c < 300) begin
      if (stalled) begin
        check_val("stall_valid", 128'(rk_valid), 128'd1);
        check_val("stall_data",  rk_data,        held);
      end
      check_val("key_ready_emit", 128'(key_ready), 128'd0);
      rk_ready  = ($urandom_range(99) >= stall_pct);
      key_valid = (poke && c == 2);
      if (rk_valid && rk_ready) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", 128'd1, 128'd0);
          done = 1'b1;
        end else begin
          e = sb_q.pop_front();
          check_val("rk_data",  rk_data,        e.data);
          check_val("rk_round", 128'(rk_round), 128'(e.round));
          check_val("rk_last",  128'(rk_last),  128'(e.round == 4'd0));
          if (spot_en[e.round]) check_val("ref_key", rk_data, spot[e.round]);
          if (e.round == 4'd0) done = 1'b1;
        end
        stalled = 1'b0;
      end else begin
        stalled = rk_valid;
        held    = rk_data;
      end
      @(posedge clk); #1; c++;
    end
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    check_val("stream_done", 128'(done), 128'd1);
    if (stall_pct == 0) check_val("stream_len", 128'(c), 128'd11);
    check_val("key_ready_after", 128'(key_ready), 128'd1);
    check_val("rk_valid_after",  128'(rk_valid),  128'd0);
  endtask

  task automatic run_key(input logic [127:0] k, input bit fips, input int stall_pct, input bit poke);
    set_spots(fips);
    push_expected(k);
    send_key(k);
    consume(stall_pct, poke, 11);
  endtask

  initial begin
    int c;
    rst_n        = 1'b0;
    key_valid    = 1'b0;
    key_in       = 128'h0;
    replay_valid = 1'b0;
    rk_ready     = 1'b0;
    build_sbox();
    #12;
    check_reset("rst_init");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_key(FIPS_KEY, 1'b1, 0, 1'b0);
    run_key(ZERO_KEY, 1'b0, 0, 1'b0);
    run_key(FIPS_KEY, 1'b1, 30, 1'b0);
    run_key(FIPS_KEY, 1'b1, 20, 1'b1);

`ifndef KEYSCHED_CACHE_EN
    check_val("no_cache_hit", 128'(cache_hit), 128'd0);
    replay_valid = 1'b1;
    @(posedge clk); #1;
    replay_valid = 1'b0;
    @(posedge clk); #1;
    check_val("replay_ignored_valid", 128'(rk_valid),  128'd0);
    check_val("replay_ignored_ready", 128'(key_ready), 128'd1);
`endif

    // Reset during the forward pass.
    send_key(FIPS_KEY);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 check_reset("rst_fwd");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_key(FIPS_KEY, 1'b1, 0, 1'b0);

    // Reset while streaming.
    send_key(ZERO_KEY);
    rk_ready = 1'b1;
    c = 0;
    while (!rk_valid && c < 40) begin
      @(posedge clk); #1; c++;
    end
    check_val("abort_valid", 128'(rk_valid), 128'd1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 check_reset("rst_emit");
    rk_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_key(ZERO_KEY, 1'b0, 0, 1'b0);

`ifdef KEYSCHED_CACHE_EN
    run_key(FIPS_KEY, 1'b1, 0, 1'b0);
    check_val("cache_hit_set", 128'(cache_hit), 128'd1);
    push_expected(FIPS_KEY);
    replay_valid = 1'b1;
    @(posedge clk); #1;
    replay_valid = 1'b0;
    consume(0, 1'b0, 1);

    set_spots(1'b0);
    push_expected(ZERO_KEY);
    key_valid    = 1'b1;
    key_in       = ZERO_KEY;
    replay_valid = 1'b1;
    @(posedge clk); #1;
    key_valid    = 1'b0;
    replay_valid = 1'b0;
    consume(0, 1'b0, 11);

    push_expected(ZERO_KEY);
    replay_valid = 1'b1;
    @(posedge clk); #1;
    replay_valid = 1'b0;
    consume(0, 1'b0, 1);
`endif

    check_val("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Sequential AES-128 round-key generator for the decryption datapath. It produces round keys in reverse order, round 10 down to round 0. A cipher key is accepted over a valid/ready handshake. The block runs the forward schedule for 10 cycles to reach the final round key, then streams each earlier key using the inverse recurrence. This lets the inverse cipher consume keys on the fly without storing all 11 round keys.

## Interface
- NR, 10, number of rounds; only 10 is supported, and elaboration fails for other values.
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  cipher key offered
- key_ready  out  1  block can accept a key; high only in IDLE
- key_in  in  128  cipher key; [127:96] is w0, MSB-first as in the forward schedule
- replay_valid  in  1  re-stream the cached key set (see Configuration)
- cache_hit  out  1  a cached final round key is held
- rk_valid  out  1  rk_data holds a round key
- rk_ready  in  1  consumer accepts rk_data
- rk_data  out  128  round key; [127:96] is word 0 of the round
- rk_round  out  4  round index of rk_data, 10..0
- rk_last  out  1  rk_round == 0

## Operation
- States:
  - IDLE: key_ready=1.
  - FWD: forward expansion.
  - EMIT: stream keys out.
- Key intake:
  - IDLE with key_valid: key_in is latched into the working register, the FWD counter is set to 1, and the block moves to FWD.
  - key_valid outside IDLE is ignored; key_ready is 0 there.
- FWD step r (1..10):
  - t = SubWord(RotWord(w3)) ^ Rcon(r)
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - After step 10, go to EMIT with rk_round=10.
- EMIT backward step from round r to r-1, with (a0..a3) = current key:
  - b3 = a3^a2, b2 = a2^a1, b1 = a1^a0
  - b0 = a0 ^ SubWord(RotWord(b3)) ^ Rcon(r)
- Rcon(r) is the top-byte constant: 01,02,04,08,10,20,40,80,1b,36 for r=1..10.
- Each rk_valid&rk_ready handshake replaces rk_data with the previous round's key and decrements rk_round.
- A handshake with rk_last=1 returns the block to IDLE.
- Only one SubWord is needed per cycle. FWD and EMIT share a single S-box word instance through a state-selected input mux.
- rk_data holds stable while rk_valid=1 and rk_ready=0.

## Timing
- Reset values: key_ready=1, rk_valid=0, rk_data=0, rk_round=0, rk_last=0, cache_hit=0; state is IDLE.
- Key handshake in cycle T: FWD occupies T+1..T+10. rk_valid=1 with rk_round=10 from T+11.
- With rk_ready held high, keys 10..0 stream in 11 consecutive cycles. key_ready=1 in the cycle after the round-0 handshake.
- Minimum key-to-key turnaround is 22 cycles; a new key_valid is accepted in the same cycle key_ready rises.
- rk_ready low stalls EMIT indefinitely with no data loss.
- rst_n asserted mid-FWD or mid-EMIT: all outputs return to reset values immediately, and the partial key is discarded. The cache is also invalidated.
- rk_valid, rk_round and rk_last are registered; there is no combinational path from rk_ready to rk_valid.

## Configuration
- Macro: KEYSCHED_CACHE_EN.
- Defined:
  - On entering EMIT from FWD, the final round key is stored in a cache register and cache_hit goes to 1.
  - replay_valid in IDLE with cache_hit=1 loads the cache into the working register and enters EMIT directly. rk_valid=1 with round 10 appears in the next cycle (1-cycle latency).
  - key_valid and replay_valid in the same IDLE cycle: key_valid wins and the cache is overwritten at the end of FWD.
  - replay_valid with cache_hit=0 is ignored.
- Undefined:
  - replay_valid is ignored, cache_hit is tied 0, and no cache register is built.
  - Ports are identical in both builds.

## Structure
- Shared package aes_pkg holds:
  - the S-box byte function
  - the Rcon function
  - the state enum (IDLE/FWD/EMIT)
  - the AES-128 constants (NK=4, NR=10)
- The forward key expansion block reuses the same package entries.
- One sub-module, aes_sub_word: combinational 32-bit SubWord of four S-box bytes, instantiated once.
- The top level contains the FSM, round counter, working register, optional cache and output registers.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+11
  - round 9 = ac7766f319fadc2128d12941575c006e
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 0 = the key, with rk_last=1
- All-zero key → round 10 = b4ef5bcb3e92e21123e951cf6f8f188e, round 0 = 0.
- Random rk_ready backpressure (e.g. 30% low) on the FIPS key → identical 11-key sequence; rk_data stable during stalls; key_ready low throughout.
- key_valid pulsed during FWD and EMIT → ignored; output sequence unchanged; next key accepted only after rk_last handshake.
- rst_n asserted at FWD step 5 and again mid-EMIT → outputs return to reset values asynchronously; fresh key afterwards yields the correct sequence.
- With KEYSCHED_CACHE_EN: FIPS key run, then replay_valid → round 10 key one cycle later, same 11 keys. Simultaneous key_valid (zero key) and replay_valid → zero-key sequence, and the cache then holds b4ef…188e.
